// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: opcodes, op-select enum, field positions, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instr_encoder_pkg;

    localparam int WORD_W = 32;
    localparam int OPC_W  = 6;

    // Bit position of the least significant bit of each instruction field.
    localparam int OPC_LSB  = 26;
    localparam int DEST_LSB = 21;
    localparam int SRC1_LSB = 16;
    localparam int SRC2_LSB = 11;

    localparam logic [OPC_W-1:0] OPC_NOP  = 6'd0;
    localparam logic [OPC_W-1:0] OPC_ADD  = 6'd1;
    localparam logic [OPC_W-1:0] OPC_SUB  = 6'd3;
    localparam logic [OPC_W-1:0] OPC_AND  = 6'd5;
    localparam logic [OPC_W-1:0] OPC_OR   = 6'd6;
    localparam logic [OPC_W-1:0] OPC_NOR  = 6'd7;
    localparam logic [OPC_W-1:0] OPC_XOR  = 6'd8;
    localparam logic [OPC_W-1:0] OPC_SLA  = 6'd9;
    localparam logic [OPC_W-1:0] OPC_SLL  = 6'd10;
    localparam logic [OPC_W-1:0] OPC_SRA  = 6'd11;
    localparam logic [OPC_W-1:0] OPC_SRL  = 6'd12;
    localparam logic [OPC_W-1:0] OPC_ADDI = 6'd32;
    localparam logic [OPC_W-1:0] OPC_SUBI = 6'd33;
    localparam logic [OPC_W-1:0] OPC_LD   = 6'd36;
    localparam logic [OPC_W-1:0] OPC_ST   = 6'd37;
    localparam logic [OPC_W-1:0] OPC_BEZ  = 6'd40;
    localparam logic [OPC_W-1:0] OPC_BNE  = 6'd41;
    localparam logic [OPC_W-1:0] OPC_JMP  = 6'd42;

    // Symbolic operation select as presented on the input stream; 18..31 are illegal.
    typedef enum logic [4:0] {
        SEL_NOP  = 5'd0,  SEL_ADD  = 5'd1,  SEL_SUB  = 5'd2,  SEL_AND  = 5'd3,
        SEL_OR   = 5'd4,  SEL_NOR  = 5'd5,  SEL_XOR  = 5'd6,  SEL_SLA  = 5'd7,
        SEL_SLL  = 5'd8,  SEL_SRA  = 5'd9,  SEL_SRL  = 5'd10, SEL_ADDI = 5'd11,
        SEL_SUBI = 5'd12, SEL_LD   = 5'd13, SEL_ST   = 5'd14, SEL_BEZ  = 5'd15,
        SEL_BNE  = 5'd16, SEL_JMP  = 5'd17
    } op_sel_e;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_PAD = 1'b1
    } enc_state_e;

    function automatic logic [OPC_W-1:0] sel_opcode(input logic [4:0] sel);
        case (sel)
            SEL_ADD:  return OPC_ADD;
            SEL_SUB:  return OPC_SUB;
            SEL_AND:  return OPC_AND;
            SEL_OR:   return OPC_OR;
            SEL_NOR:  return OPC_NOR;
            SEL_XOR:  return OPC_XOR;
            SEL_SLA:  return OPC_SLA;
            SEL_SLL:  return OPC_SLL;
            SEL_SRA:  return OPC_SRA;
            SEL_SRL:  return OPC_SRL;
            SEL_ADDI: return OPC_ADDI;
            SEL_SUBI: return OPC_SUBI;
            SEL_LD:   return OPC_LD;
            SEL_ST:   return OPC_ST;
            SEL_BEZ:  return OPC_BEZ;
            SEL_BNE:  return OPC_BNE;
            SEL_JMP:  return OPC_JMP;
            default:  return OPC_NOP;
        endcase
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Packs one symbolic instruction into a 32-bit word and flags illegal selects and branches.
// Latency: combinational.
// Backpressure: none; caller owns the handshake.
// Ports: op_sel_i/dest_i/src1_i/src2_i/imm_i symbolic fields in; word_o packed word,
//        illegal_o select has no encoding, branch_o select is BEZ/BNE/JMP.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [4:0]        op_sel_i,
    input  logic [4:0]        dest_i,
    input  logic [4:0]        src1_i,
    input  logic [4:0]        src2_i,
    input  logic [15:0]       imm_i,
    output logic [WORD_W-1:0] word_o,
    output logic              illegal_o,
    output logic              branch_o
);

    logic [OPC_W-1:0] opc;

    always_comb begin
        opc       = sel_opcode(op_sel_i);
        word_o    = '0;
        illegal_o = 1'b0;
        branch_o  = 1'b0;
        case (op_sel_i)
            SEL_NOP: word_o = '0;
            SEL_ADD, SEL_SUB, SEL_AND, SEL_OR, SEL_NOR, SEL_XOR,
            SEL_SLA, SEL_SLL, SEL_SRA, SEL_SRL: begin
                word_o = (WORD_W'(opc)    << OPC_LSB)
                       | (WORD_W'(dest_i) << DEST_LSB)
                       | (WORD_W'(src1_i) << SRC1_LSB)
                       | (WORD_W'(src2_i) << SRC2_LSB);
            end
            SEL_ADDI, SEL_SUBI, SEL_LD, SEL_ST: begin
                word_o = (WORD_W'(opc)    << OPC_LSB)
                       | (WORD_W'(dest_i) << DEST_LSB)
                       | (WORD_W'(src1_i) << SRC1_LSB)
                       | WORD_W'(imm_i);
            end
            SEL_BEZ: begin
                word_o   = (WORD_W'(opc)    << OPC_LSB)
                         | (WORD_W'(src1_i) << SRC1_LSB)
                         | WORD_W'(imm_i);
                branch_o = 1'b1;
            end
            // BNE carries its second compare register in the dest slot.
            SEL_BNE: begin
                word_o   = (WORD_W'(opc)    << OPC_LSB)
                         | (WORD_W'(src2_i) << DEST_LSB)
                         | (WORD_W'(src1_i) << SRC1_LSB)
                         | WORD_W'(imm_i);
                branch_o = 1'b1;
            end
            SEL_JMP: begin
                word_o   = (WORD_W'(opc) << OPC_LSB) | WORD_W'(imm_i);
                branch_o = 1'b1;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming instruction encoder / program loader: symbolic ops in, {word, byte address} out.
// Latency: 1 cycle from accepted input to out_valid; 1 word/cycle while out_ready is high.
// Backpressure: single output register; in_ready drops while it is full and out_ready is low.
// Ports: clk, rst (async, active-low), start (restart program, clear done/err),
//        in_* symbolic instruction with valid/ready, out_* word/address with valid/ready,
//        done (DEPTH words emitted, sticky), err (illegal select seen, sticky).
// Build option: define NOP_PAD_EN to append PAD_COUNT NOP words after every branch/jump.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned PAD_COUNT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_op,
    input  logic [4:0]  in_dest,
    input  logic [4:0]  in_src1,
    input  logic [4:0]  in_src2,
    input  logic [15:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [31:0] out_addr,
    output logic        done,
    output logic        err
);

    localparam int IDX_W = $clog2(DEPTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam int PAD_W = (PAD_COUNT > 1) ? $clog2(PAD_COUNT) : 1;
    localparam logic [PAD_W-1:0] LAST_PAD = (PAD_COUNT > 0) ? PAD_W'(PAD_COUNT - 1) : '0;
`ifdef NOP_PAD_EN
    localparam bit PAD_EN = (PAD_COUNT != 0);
`else
    localparam bit PAD_EN = 1'b0;
`endif

    enc_state_e        state_q, state_d;
    logic [PAD_W-1:0]  pad_cnt_q, pad_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_word_q, out_word_d;
    logic [31:0]       out_addr_q, out_addr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [31:0]       pk_word;
    logic              pk_illegal;
    logic              pk_branch;

    logic              slot_free;
    logic              accept;
    logic              load_in;
    logic              load_pad;
    logic              load;
    logic              load_last;

    instr_pack u_pack (
        .op_sel_i  (in_op),
        .dest_i    (in_dest),
        .src1_i    (in_src1),
        .src2_i    (in_src2),
        .imm_i     (in_imm),
        .word_o    (pk_word),
        .illegal_o (pk_illegal),
        .branch_o  (pk_branch)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_RUN;
            pad_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pad_cnt_q <= pad_cnt_d;
        end
    end

    // FSM outputs: handshake and load strobes.
    always_comb begin
        slot_free = !out_valid_q || out_ready;
        // Gated by rst so the stream never sees ready while reset is held.
        in_ready  = rst && (state_q == ST_RUN) && !done_q && !start && slot_free;
        accept    = in_valid && in_ready;
        load_in   = accept && !pk_illegal;
        load_pad  = (state_q == ST_PAD) && !start && slot_free;
        load      = load_in || load_pad;
        load_last = load && (idx_q == LAST_IDX);
    end

    // FSM next state. A branch that is itself the final word has nowhere to pad into.
    always_comb begin
        state_d   = state_q;
        pad_cnt_d = pad_cnt_q;
        if (start) begin
            state_d   = ST_RUN;
            pad_cnt_d = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (PAD_EN && load_in && pk_branch && !load_last) begin
                        state_d   = ST_PAD;
                        pad_cnt_d = '0;
                    end
                end
                ST_PAD: begin
                    if (load_pad) begin
                        if (load_last || pad_cnt_q == LAST_PAD) begin
                            state_d = ST_RUN;
                        end else begin
                            pad_cnt_d = pad_cnt_q + PAD_W'(1);
                        end
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // Output register, word index and sticky flags.
    always_comb begin
        out_valid_d = out_valid_q && !out_ready;
        out_word_d  = out_word_q;
        out_addr_d  = out_addr_q;
        idx_d       = idx_q;
        done_d      = done_q;
        err_d       = err_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_word_d  = load_pad ? '0 : pk_word;
            out_addr_d  = BASE_ADDR + (32'(idx_q) << 2);
            idx_d       = idx_q + IDX_W'(1);
            if (load_last) begin
                done_d = 1'b1;
            end
        end
        if (accept && pk_illegal) begin
            err_d = 1'b1;
        end
        // start never coincides with a load, so it only needs to clear the program state.
        if (start) begin
            idx_d  = '0;
            done_d = 1'b0;
            err_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_addr_q  <= BASE_ADDR;
            idx_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            out_addr_q  <= out_addr_d;
            idx_q       <= idx_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_word  = out_word_q;
    assign out_addr  = out_addr_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios plus a randomized stream against a transaction model.
// Model: expected words live in a queue; the head is the word currently held in the output register.
// Build with or without NOP_PAD_EN; the branch scenario adapts.
module tb_instr_encoder;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_0400;
    localparam int          PADC  = 2;
`ifdef NOP_PAD_EN
    localparam bit PAD_ON = 1'b1;
`else
    localparam bit PAD_ON = 1'b0;
`endif
    localparam int unsigned OPC_TAB [18] = '{0, 1, 3, 5, 6, 7, 8, 9, 10, 11, 12, 32, 33, 36, 37, 40, 41, 42};
    localparam int unsigned P26 = 32'd67108864;
    localparam int unsigned P21 = 32'd2097152;
    localparam int unsigned P16 = 32'd65536;
    localparam int unsigned P11 = 32'd2048;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_op = '0;
    logic [4:0]  in_dest = '0;
    logic [4:0]  in_src1 = '0;
    logic [4:0]  in_src2 = '0;
    logic [15:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_word;
    logic [31:0] out_addr;
    logic        done;
    logic        err;

    instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .PAD_COUNT(PADC)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_dest(in_dest), .in_src1(in_src1), .in_src2(in_src2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_addr(out_addr),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        logic [31:0] addr;
        bit          last;
        int          gen;
    } exp_t;

    exp_t q[$];
    int   gen = 0;
    int   idx_m = 0;
    bit   done_m = 1'b0;
    bit   err_m = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    // Instruction word from the ISA table, built with plain arithmetic.
    function automatic void ref_encode(input int unsigned sel, input int unsigned d, input int unsigned s1,
                                       input int unsigned s2, input int unsigned imm,
                                       output bit ill, output bit br, output logic [31:0] w);
        int unsigned o;
        ill = (sel > 17);
        br  = (sel >= 15) && (sel <= 17);
        w   = '0;
        if (!ill && sel != 0) begin
            o = OPC_TAB[sel];
            if (sel <= 10)      w = o * P26 + d * P21 + s1 * P16 + s2 * P11;
            else if (sel <= 14) w = o * P26 + d * P21 + s1 * P16 + imm;
            else if (sel == 15) w = o * P26 + s1 * P16 + imm;
            else if (sel == 16) w = o * P26 + s2 * P21 + s1 * P16 + imm;
            else                w = o * P26 + imm;
        end
    endfunction

    function automatic void push_exp(input logic [31:0] w);
        exp_t e;
        e.word = w;
        e.addr = BASE + 32'(4 * idx_m);
        e.last = (idx_m == DEPTH - 1);
        e.gen  = gen;
        q.push_back(e);
        idx_m++;
    endfunction

    function automatic void model_reset();
        q.delete();
        gen++;
        idx_m  = 0;
        done_m = 1'b0;
        err_m  = 1'b0;
    endfunction

    // One clock of stimulus: drive after the falling edge, compare the DUT against the model,
    // then advance the model across the rising edge.
    task automatic drive_cycle(input bit st, input bit iv, input logic [4:0] op, input logic [4:0] d,
                               input logic [4:0] s1, input logic [4:0] s2, input logic [15:0] imm,
                               input bit ordy);
        bit exp_ready, exp_valid, popped, ill, br;
        logic [31:0] w;
        @(negedge clk);
        start = st; in_valid = iv; in_op = op; in_dest = d; in_src1 = s1; in_src2 = s2;
        in_imm = imm; out_ready = ordy;
        #1;
        exp_valid = (q.size() > 0);
        exp_ready = !done_m && !st && (q.size() <= 1) && (!exp_valid || ordy);
        n_cmp++;
        if (in_ready !== exp_ready) begin
            n_err++; $display("FAIL sb_in_ready: got %b want %b at %0t", in_ready, exp_ready, $time);
        end
        n_cmp++;
        if (out_valid !== exp_valid) begin
            n_err++; $display("FAIL sb_out_valid: got %b want %b at %0t", out_valid, exp_valid, $time);
        end
        if (exp_valid) begin
            n_cmp++;
            if (out_word !== q[0].word) begin
                n_err++; $display("FAIL sb_out_word: got %h want %h at %0t", out_word, q[0].word, $time);
            end
            n_cmp++;
            if (out_addr !== q[0].addr) begin
                n_err++; $display("FAIL sb_out_addr: got %h want %h at %0t", out_addr, q[0].addr, $time);
            end
        end
        n_cmp++;
        if (done !== done_m) begin
            n_err++; $display("FAIL sb_done: got %b want %b at %0t", done, done_m, $time);
        end
        n_cmp++;
        if (err !== err_m) begin
            n_err++; $display("FAIL sb_err: got %b want %b at %0t", err, err_m, $time);
        end
        @(posedge clk);
        popped = exp_valid && ordy;
        if (popped) void'(q.pop_front());
        if (st) begin
            gen++;
            idx_m  = 0;
            done_m = 1'b0;
            err_m  = 1'b0;
            if (popped) q.delete();
            else while (q.size() > 1) void'(q.pop_back());
        end else if (iv && exp_ready) begin
            ref_encode(op, d, s1, s2, imm, ill, br, w);
            if (ill) err_m = 1'b1;
            else begin
                push_exp(w);
                if (br && PAD_ON)
                    for (int p = 0; p < PADC && idx_m < DEPTH; p++) push_exp('0);
            end
        end
        if (q.size() > 0 && q[0].last && q[0].gen == gen) done_m = 1'b1;
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, '0, '0, '0, '0, '0, ordy);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0)  begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_word !== 32'h0) begin n_err++; $display("FAIL rst_out_word: got %h want 0", out_word); end
        n_cmp++; if (out_addr !== BASE)  begin n_err++; $display("FAIL rst_out_addr: got %h want %h", out_addr, BASE); end
        n_cmp++; if (done !== 1'b0)      begin n_err++; $display("FAIL rst_done: got %b want 0", done); end
        n_cmp++; if (err !== 1'b0)       begin n_err++; $display("FAIL rst_err: got %b want 0", err); end
        rst = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_add();
        drive_cycle(1'b0, 1'b1, 5'd1, 5'd3, 5'd1, 5'd2, '0, 1'b1);
        #1;
        n_cmp++; if (out_valid !== 1'b1)         begin n_err++; $display("FAIL add_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_word !== 32'h04611000)  begin n_err++; $display("FAIL add_word: got %h want 04611000", out_word); end
        n_cmp++; if (out_addr !== BASE)          begin n_err++; $display("FAIL add_addr: got %h want %h", out_addr, BASE); end
        idle(1, 1'b1);
    endtask

    task automatic test_stall();
        drive_cycle(1'b1, 1'b0, '0, '0, '0, '0, '0, 1'b1);
        drive_cycle(1'b0, 1'b1, 5'd13, 5'd4, 5'd0, 5'd0, 16'h0010, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'b1, 5'd1, 5'd7, 5'd7, 5'd7, '0, 1'b0);
            #1;
            n_cmp++; if (out_word !== 32'h90800010) begin n_err++; $display("FAIL stall_word: got %h want 90800010", out_word); end
            n_cmp++; if (out_addr !== BASE)         begin n_err++; $display("FAIL stall_addr: got %h want %h", out_addr, BASE); end
            n_cmp++; if (in_ready !== 1'b0)         begin n_err++; $display("FAIL stall_ready: got %b want 0", in_ready); end
        end
        idle(1, 1'b1);
    endtask

    task automatic test_illegal();
        drive_cycle(1'b1, 1'b0, '0, '0, '0, '0, '0, 1'b1);
        drive_cycle(1'b0, 1'b1, 5'd25, 5'd1, 5'd1, 5'd1, 16'h1234, 1'b1);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL illegal_no_word: got %b want 0", out_valid); end
        n_cmp++; if (err !== 1'b1)       begin n_err++; $display("FAIL illegal_err: got %b want 1", err); end
        drive_cycle(1'b0, 1'b1, 5'd11, 5'd2, 5'd7, 5'd0, 16'hBEEF, 1'b1);
        #1;
        n_cmp++; if (out_word !== 32'h8047BEEF) begin n_err++; $display("FAIL addi_word: got %h want 8047beef", out_word); end
        n_cmp++; if (out_addr !== BASE)         begin n_err++; $display("FAIL addi_addr: got %h want %h", out_addr, BASE); end
        idle(1, 1'b1);
    endtask

    task automatic test_depth();
        logic [31:0] seen[$];
        drive_cycle(1'b1, 1'b0, '0, '0, '0, '0, '0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            drive_cycle(1'b0, k < 6, 5'd2, 5'(k), 5'd1, 5'd2, '0, 1'b1);
            #1;
            if (out_valid) seen.push_back(out_addr);
        end
        n_cmp++; if (seen.size() != DEPTH) begin n_err++; $display("FAIL depth_count: got %0d want %0d", seen.size(), DEPTH); end
        for (int k = 0; k < seen.size() && k < DEPTH; k++) begin
            n_cmp++;
            if (seen[k] !== BASE + 32'(4 * k)) begin
                n_err++; $display("FAIL depth_addr%0d: got %h want %h", k, seen[k], BASE + 32'(4 * k));
            end
        end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL depth_done: got %b want 1", done); end
        drive_cycle(1'b0, 1'b1, 5'd1, 5'd1, 5'd1, 5'd1, '0, 1'b1);
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL depth_ready: got %b want 0", in_ready); end
        drive_cycle(1'b1, 1'b0, '0, '0, '0, '0, '0, 1'b1);
        #1;
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL restart_done: got %b want 1'b0", done); end
        drive_cycle(1'b0, 1'b1, 5'd1, 5'd3, 5'd1, 5'd2, '0, 1'b1);
        #1;
        n_cmp++; if (out_addr !== BASE) begin n_err++; $display("FAIL restart_addr: got %h want %h", out_addr, BASE); end
        idle(1, 1'b1);
    endtask

    task automatic test_branch();
        drive_cycle(1'b1, 1'b0, '0, '0, '0, '0, '0, 1'b1);
        drive_cycle(1'b0, 1'b1, 5'd17, 5'd9, 5'd9, 5'd9, 16'h0005, 1'b1);
        #1;
        n_cmp++; if (out_word !== 32'hA8000005) begin n_err++; $display("FAIL jmp_word: got %h want a8000005", out_word); end
        n_cmp++; if (out_addr !== BASE)         begin n_err++; $display("FAIL jmp_addr: got %h want %h", out_addr, BASE); end
        if (PAD_ON) begin
            for (int p = 0; p < PADC; p++) begin
                n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL pad_ready%0d: got %b want 0", p, in_ready); end
                drive_cycle(1'b0, 1'b1, 5'd1, 5'd3, 5'd1, 5'd2, '0, 1'b1);
                #1;
                n_cmp++; if (out_word !== 32'h0) begin n_err++; $display("FAIL pad_word%0d: got %h want 0", p, out_word); end
                n_cmp++;
                if (out_addr !== BASE + 32'(4 * (p + 1))) begin
                    n_err++; $display("FAIL pad_addr%0d: got %h want %h", p, out_addr, BASE + 32'(4 * (p + 1)));
                end
            end
        end else begin
            drive_cycle(1'b0, 1'b1, 5'd1, 5'd3, 5'd1, 5'd2, '0, 1'b1);
            #1;
            n_cmp++; if (out_word !== 32'h04611000) begin n_err++; $display("FAIL after_jmp_word: got %h want 04611000", out_word); end
            n_cmp++; if (out_addr !== BASE + 32'd4) begin n_err++; $display("FAIL after_jmp_addr: got %h want %h", out_addr, BASE + 32'd4); end
        end
        idle(2, 1'b1);
    endtask

    task automatic test_random();
        logic [4:0] op;
        drive_cycle(1'b1, 1'b0, '0, '0, '0, '0, '0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(18, 31)) : 5'($urandom_range(0, 17));
            drive_cycle($urandom_range(0, 24) == 0, $urandom_range(0, 9) < 7, op,
                        5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom),
                        $urandom_range(0, 9) < 6);
        end
        idle(3, 1'b1);
    endtask

    task automatic test_reset_mid();
        drive_cycle(1'b1, 1'b0, '0, '0, '0, '0, '0, 1'b1);
        drive_cycle(1'b0, 1'b1, 5'd30, '0, '0, '0, '0, 1'b1);
        drive_cycle(1'b0, 1'b1, 5'd13, 5'd4, 5'd0, 5'd0, 16'h0010, 1'b0);
        drive_cycle(1'b0, 1'b0, '0, '0, '0, '0, '0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0; start = 1'b0; out_ready = 1'b0;
        n_cmp++; if (err !== 1'b1)       begin n_err++; $display("FAIL pre_reset_err: got %b want 1", err); end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL pre_reset_valid: got %b want 1", out_valid); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_addr !== BASE)  begin n_err++; $display("FAIL mid_rst_addr: got %h want %h", out_addr, BASE); end
        n_cmp++; if (err !== 1'b0)       begin n_err++; $display("FAIL mid_rst_err: got %b want 0", err); end
        n_cmp++; if (in_ready !== 1'b0)  begin n_err++; $display("FAIL mid_rst_ready: got %b want 0", in_ready); end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_cycle(1'b0, 1'b1, 5'd16, 5'd0, 5'd5, 5'd6, 16'h00FF, 1'b1);
        idle(3, 1'b1);
    endtask

    initial begin
        test_reset();
        test_add();
        test_stall();
        test_illegal();
        test_depth();
        test_branch();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Streaming instruction encoder and program loader: the write-side counterpart of the decode stage.
- Accepts symbolic instructions (operation select plus register and immediate fields) over a valid/ready handshake.
- Packs each into the 32-bit processor instruction word: opcode [31:26], dest [25:21], src1 [20:16], src2 [15:11] / imm [15:0].
- Emits each word with its byte address toward the instruction-memory write port, for testbenches and the boot loader.

Parameters:
- DEPTH, 1024, instruction words the target memory holds; emission stops after DEPTH words.
- BASE_ADDR, 32'h0, byte address of the first emitted word.
- PAD_COUNT, 1, NOPs inserted after each branch/jump (used only with NOP_PAD_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  pulse: restart the program at BASE_ADDR and clear done/err.
- in_valid  in  1  input instruction valid.
- in_ready  out  1  encoder accepts input this cycle.
- in_op  in  5  operation select (see Behaviour).
- in_dest  in  5  destination register, or store-data register for ST.
- in_src1  in  5  source register 1.
- in_src2  in  5  source register 2 (R-type, BNE).
- in_imm  in  16  immediate / offset.
- out_valid  out  1  out_word/out_addr valid.
- out_ready  in  1  memory side accepts the word.
- out_word  out  32  encoded instruction.
- out_addr  out  32  byte address, BASE_ADDR + 4*index.
- done  out  1  DEPTH words emitted; sticky until start.
- err  out  1  sticky: an illegal in_op was seen.

Behaviour:
- Reset values: in_ready=0 during reset; out_valid=0, out_word=0, out_addr=BASE_ADDR, done=0, err=0, word index=0, state=RUN.
- in_op mapping (select -> opcode):
  - 0 NOP -> 0; 1 ADD -> 1; 2 SUB -> 3; 3 AND -> 5; 4 OR -> 6; 5 NOR -> 7; 6 XOR -> 8.
  - 7 SLA -> 9; 8 SLL -> 10; 9 SRA -> 11; 10 SRL -> 12.
  - 11 ADDI -> 32; 12 SUBI -> 33; 13 LD -> 36; 14 ST -> 37.
  - 15 BEZ -> 40; 16 BNE -> 41; 17 JMP -> 42.
  - 18-31 illegal.
- Word formats:
  - NOP: all zero.
  - R-type: {op, dest, src1, src2, 11'b0}.
  - ADDI/SUBI/LD/ST: {op, dest, src1, imm}.
  - BEZ: {op, 5'b0, src1, imm}.
  - BNE: {op, src2, src1, imm}.
  - JMP: {op, 10'b0, imm}.
- Handshake:
  - Input is accepted when in_valid && in_ready.
  - in_ready = state==RUN && !done && !start && (!out_valid || out_ready).
  - Output is a single register stage: an accepted word appears on out_valid at the next edge (latency 1). Full throughput of 1 word/cycle holds while out_ready=1.
  - out_word/out_addr are held stable while out_valid && !out_ready.
- Addressing:
  - out_addr for word k is BASE_ADDR+4k.
  - The index increments on each emitted (loaded) word, never wraps.
  - When the loaded word is index DEPTH-1, done is set at the same edge and in_ready falls.
- Illegal op:
  - Consumed (handshake completes), no word emitted, index unchanged.
  - err set next edge and held until start or reset.
- start:
  - Takes precedence over in_valid; same-cycle input is not accepted.
  - A pending out_valid word completes its handshake first; start still takes effect that cycle.
  - Effect: index=0, done=0, err=0, state=RUN.
- Async reset mid-operation: all state cleared immediately; a partially transferred word is dropped.
- States: RUN (normal), PAD (optional feature only).

Optional Feature:
- Macro NOP_PAD_EN.
- Defined:
  - After a BEZ/BNE/JMP word is loaded, state goes to PAD.
  - PAD emits PAD_COUNT all-zero NOP words at consecutive addresses, using the same output handshake; in_ready=0 throughout.
  - Returns to RUN after the last NOP.
  - If DEPTH is reached during PAD, the remaining NOPs are dropped, done=1, state=RUN.
  - start during PAD aborts the padding.
- Undefined: no PAD state; branches are emitted like any other word; PAD_COUNT is unused.

Decomposition:
- Shared package holds:
  - opcode constants (the 6-bit values above);
  - the in_op select enum;
  - field bit-position localparams;
  - the state enum.
- One sub-module: instr_pack, purely combinational (in_op plus fields -> word, illegal flag), reused by the assembler testbench model.
- instr_encoder holds the FSM, index counter, output register and flags.

Test Plan:
- ADD (in_op=1, dest=3, src1=1, src2=2), out_ready=1 -> next cycle out_word=32'h04611000, out_addr=0.
- LD dest=4, src1=0, imm=16'h0010 held with out_ready=0 for 3 cycles -> out_word=32'h90800010 stable; in_ready=0 until out_ready=1.
- in_op=25 -> handshake completes, no out_valid, err=1; next ADDI still lands at the same address.
- DEPTH=4, stream 6 legal ops -> 4 words at addresses 0,4,8,12; done=1; in_ready stays 0; start -> index 0, done=0.
- With NOP_PAD_EN, PAD_COUNT=2: JMP imm=5 -> 32'hA8000005 @0, then NOPs @4 and @8, in_ready=0 for 2 cycles.
- Reset asserted while out_valid=1 and out_ready=0 -> out_valid=0 immediately, out_addr=BASE_ADDR, err=0.
